// File: rtl/ct_f_spsram_2048x32_ctrl.sv
// Two-port arbitrated controller for a 2048x32 single-port SRAM macro with a
// power-up sweep that writes every word before normal requests are granted.
module ct_f_spsram_2048x32_ctrl #(
    parameter bit          INIT_EN    = 1'b1,
    parameter logic [31:0] INIT_VALUE = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        req0_vld,
    input  logic        req0_wr,
    input  logic [10:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_be,
    output logic        req0_rdy,

    input  logic        req1_vld,
    input  logic        req1_wr,
    input  logic [10:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_be,
    output logic        req1_rdy,

    output logic        rsp0_vld,
    output logic [31:0] rsp0_rdata,
    output logic        rsp1_vld,
    output logic [31:0] rsp1_rdata,

    output logic        init_busy,

    output logic [10:0] A,
    output logic        CEN,
    output logic        GWEN,
    output logic [31:0] WEN,
    output logic [31:0] D,
    input  logic [31:0] Q
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [10:0] init_cnt;
    logic        rr_ptr;
    logic        rst_q;
    logic        rsp0_q;
    logic        rsp1_q;

    logic        quiet;
    logic        sweep;
    logic        run;
    logic        gnt0;
    logic        gnt1;
    logic        sel_wr;
    logic [10:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_be;

    // The SRAM stays idle while reset is asserted and for one cycle after it
    // is released; the sweep or first grant happens on the cycle after that.
    assign quiet = RST | rst_q;
    assign sweep = (state == ST_INIT) & ~quiet;
    assign run   = (state == ST_RUN)  & ~quiet;

    assign gnt0 = run & req0_vld & (~req1_vld | ~rr_ptr);
    assign gnt1 = run & req1_vld & (~req0_vld |  rr_ptr);

    assign req0_rdy  = gnt0;
    assign req1_rdy  = gnt1;
    assign init_busy = (state == ST_INIT);

    assign sel_wr    = gnt1 ? req1_wr    : req0_wr;
    assign sel_addr  = gnt1 ? req1_addr  : req0_addr;
    assign sel_wdata = gnt1 ? req1_wdata : req0_wdata;
    assign sel_be    = gnt1 ? req1_be    : req0_be;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        A    = '0;
        CEN  = 1'b1;
        GWEN = 1'b1;
        WEN  = '1;
        D    = '0;
        if (sweep) begin
            A    = init_cnt;
            CEN  = 1'b0;
            GWEN = 1'b0;
            WEN  = '0;
            D    = INIT_VALUE;
        end else if (gnt0 || gnt1) begin
            A   = sel_addr;
            CEN = 1'b0;
            D   = sel_wdata;
            if (sel_wr) begin
                GWEN = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    WEN[8*k +: 8] = {8{~sel_be[k]}};
                end
            end
        end
    end

    // A reset arriving in the response cycle suppresses the pending response.
    assign rsp0_vld   = rsp0_q & ~RST;
    assign rsp1_vld   = rsp1_q & ~RST;
    assign rsp0_rdata = rsp0_vld ? Q : '0;
    assign rsp1_rdata = rsp1_vld ? Q : '0;

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            state    <= INIT_EN ? ST_INIT : ST_RUN;
            init_cnt <= '0;
            rr_ptr   <= 1'b0;
            rst_q    <= 1'b1;
            rsp0_q   <= 1'b0;
            rsp1_q   <= 1'b0;
        end else begin
            rst_q  <= 1'b0;
            rsp0_q <= gnt0 & ~req0_wr;
            rsp1_q <= gnt1 & ~req1_wr;
            if (gnt0) begin
                rr_ptr <= 1'b1;
            end else if (gnt1) begin
                rr_ptr <= 1'b0;
            end
            if (sweep) begin
                init_cnt <= init_cnt + 11'd1;
                if (init_cnt == 11'h7FF) begin
                    state <= ST_RUN;
                end
            end
        end
    end

endmodule
